// File: rtl/multibank_pingpong_ram_if.sv
// Producer/consumer bus of the N-bank rotating buffer.
// The master drives fills, reads and release strobes; the slave is the buffer.
interface multibank_pingpong_ram_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned NBANK  = 2
);
    localparam int unsigned BANK_W = $clog2(NBANK);

    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic [DATA_W-1:0] wr_din;
    logic              wr_finish;
    logic              wr_ready;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_dout;
    logic              rd_valid;
    logic              rd_finish;
    logic              rd_ready;
    logic [BANK_W-1:0] rd_bank;
    logic [ADDR_W:0]   rd_len;
    logic [BANK_W:0]   used;
    logic              err;

    modport master (
        output wr_addr, wr_en, wr_din, wr_finish, rd_addr, rd_en, rd_finish,
        input  wr_ready, wr_bank, rd_dout, rd_valid, rd_ready, rd_bank, rd_len, used, err
    );

    modport slave (
        input  wr_addr, wr_en, wr_din, wr_finish, rd_addr, rd_en, rd_finish,
        output wr_ready, wr_bank, rd_dout, rd_valid, rd_ready, rd_bank, rd_len, used, err
    );
endinterface

// File: rtl/multibank_pingpong_ram.sv
// N-bank rotating buffer: the writer fills and releases banks in order, the
// reader drains them in the same order and hands each back to the writer.
module multibank_pingpong_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned NBANK  = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    multibank_pingpong_ram_if.slave     bus
);
    localparam int unsigned BANK_W = $clog2(NBANK);
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = BANK_W + 1;
    localparam int unsigned NWORD  = NBANK * DEPTH;

    logic [DATA_W-1:0] mem [NWORD];

    logic [BANK_W-1:0] wr_ptr_q, wr_ptr_n;
    logic [BANK_W-1:0] rd_ptr_q, rd_ptr_n;
    logic [CNT_W-1:0]  used_q, used_n;
    logic [LEN_W-1:0]  cur_len_q, cur_len_n, cur_upd;
    logic [LEN_W-1:0]  len_q [NBANK];
    logic [LEN_W-1:0]  len_n [NBANK];
    logic [LEN_W-1:0]  wr_len;
    logic [LEN_W-1:0]  rd_len_q, rd_len_n;
    logic              wr_ready_q, rd_ready_q;
    logic              err_q, err_n;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_dout_q;

    // Acceptance always uses the registered (pre-edge) ownership flags.
    logic wr_acc, wr_rej, wf_acc, wf_rej, rd_acc, rd_rej, rf_acc, rf_rej;
    assign wr_acc = bus.wr_en     &&  wr_ready_q;
    assign wr_rej = bus.wr_en     && !wr_ready_q;
    assign wf_acc = bus.wr_finish &&  wr_ready_q;
    assign wf_rej = bus.wr_finish && !wr_ready_q;
    assign rd_acc = bus.rd_en     &&  rd_ready_q;
    assign rd_rej = bus.rd_en     && !rd_ready_q;
    assign rf_acc = bus.rd_finish &&  rd_ready_q;
    assign rf_rej = bus.rd_finish && !rd_ready_q;

    // Next-state for pointers, occupancy, fill lengths and the error flag.
    always_comb begin
        wr_ptr_n  = wr_ptr_q;
        rd_ptr_n  = rd_ptr_q;
        used_n    = used_q;
        len_n     = len_q;
        err_n     = err_q | wr_rej | wf_rej | rd_rej | rf_rej;
        wr_len    = LEN_W'(bus.wr_addr) + LEN_W'(1);
        cur_upd   = cur_len_q;
        if (wr_acc && (wr_len > cur_len_q)) begin
            cur_upd = wr_len;
        end
        cur_len_n = cur_upd;
        // A write in the finishing cycle still counts toward the old bank.
        if (wf_acc) begin
            len_n[wr_ptr_q] = cur_upd;
            wr_ptr_n        = wr_ptr_q + BANK_W'(1);
            cur_len_n       = '0;
        end
        if (rf_acc) begin
            rd_ptr_n = rd_ptr_q + BANK_W'(1);
        end
        case ({wf_acc, rf_acc})
            2'b10:   used_n = used_q + CNT_W'(1);
            2'b01:   used_n = used_q - CNT_W'(1);
            default: used_n = used_q;
        endcase
        rd_len_n = (used_n != '0) ? len_n[rd_ptr_n] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            used_q     <= '0;
            cur_len_q  <= '0;
            len_q      <= '{default: '0};
            rd_len_q   <= '0;
            wr_ready_q <= 1'b1;
            rd_ready_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_n;
            rd_ptr_q   <= rd_ptr_n;
            used_q     <= used_n;
            cur_len_q  <= cur_len_n;
            len_q      <= len_n;
            rd_len_q   <= rd_len_n;
            wr_ready_q <= (used_n != CNT_W'(NBANK));
            rd_ready_q <= (used_n != '0);
            err_q      <= err_n;
        end
    end

    // Storage is never cleared; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (rstn && wr_acc) begin
            mem[{wr_ptr_q, bus.wr_addr}] <= bus.wr_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_valid_q <= 1'b0;
            rd_dout_q  <= '0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_dout_q <= mem[{rd_ptr_q, bus.rd_addr}];
            end
        end
    end

    assign bus.wr_ready = wr_ready_q;
    assign bus.wr_bank  = wr_ptr_q;
    assign bus.rd_ready = rd_ready_q;
    assign bus.rd_bank  = rd_ptr_q;
    assign bus.rd_len   = rd_len_q;
    assign bus.used     = used_q;
    assign bus.err      = err_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_dout  = rd_dout_q;
endmodule

// File: tb/tb_multibank_pingpong_ram.sv
// Directed bench for the rotating bank buffer, with a 2-bank and a 4-bank instance.
module tb_multibank_pingpong_ram;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   lens [4];

    always #5 clk = ~clk;

    multibank_pingpong_ram_if #(.DATA_W(8), .ADDR_W(7), .NBANK(2)) m2 ();
    multibank_pingpong_ram_if #(.DATA_W(8), .ADDR_W(7), .NBANK(4)) m4 ();

    multibank_pingpong_ram #(.DATA_W(8), .ADDR_W(7), .NBANK(2)) u_dut2 (
        .clk(clk), .rstn(rstn), .bus(m2.slave));
    multibank_pingpong_ram #(.DATA_W(8), .ADDR_W(7), .NBANK(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .bus(m4.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tag4(input int b, input int a);
        return 8'((b << 6) | (a & 63));
    endfunction

    initial begin
        m2.wr_addr = '0; m2.wr_en = 0; m2.wr_din = '0; m2.wr_finish = 0;
        m2.rd_addr = '0; m2.rd_en = 0; m2.rd_finish = 0;
        m4.wr_addr = '0; m4.wr_en = 0; m4.wr_din = '0; m4.wr_finish = 0;
        m4.rd_addr = '0; m4.rd_en = 0; m4.rd_finish = 0;

        // Reset then idle
        tick(); tick();
        rstn = 1'b1;
        tick();
        check("rst_wr_ready", m2.wr_ready, 1);
        check("rst_rd_ready", m2.rd_ready, 0);
        check("rst_used", m2.used, 0);
        check("rst_err", m2.err, 0);
        check("rst_rd_valid", m2.rd_valid, 0);
        check("rst_rd_dout", m2.rd_dout, 0);
        check("rst_rd_len", m2.rd_len, 0);
        check("rst4_wr_ready", m4.wr_ready, 1);

        // Full bank fill; finish coincides with the last write
        for (int a = 0; a < 128; a++) begin
            m2.wr_en = 1; m2.wr_addr = 7'(a); m2.wr_din = 8'(a) ^ 8'h5A;
            m2.wr_finish = (a == 127);
            tick();
        end
        m2.wr_en = 0; m2.wr_finish = 0;
        check("fill_rd_ready", m2.rd_ready, 1);
        check("fill_rd_len", m2.rd_len, 128);
        check("fill_wr_bank", m2.wr_bank, 1);
        check("fill_used", m2.used, 1);
        check("fill_rd_bank", m2.rd_bank, 0);
        for (int a = 0; a < 128; a++) begin
            m2.rd_en = 1; m2.rd_addr = 7'(a);
            tick();
            check("stream_valid", m2.rd_valid, 1);
            check("stream_dout", m2.rd_dout, 8'(a) ^ 8'h5A);
        end
        m2.rd_en = 0;
        tick();
        check("idle_valid", m2.rd_valid, 0);
        check("idle_dout_hold", m2.rd_dout, 8'h25);

        // Simultaneous finish on both sides; the released bank is empty
        m2.wr_finish = 1; m2.rd_finish = 1;
        tick();
        m2.wr_finish = 0; m2.rd_finish = 0;
        check("sim_used", m2.used, 1);
        check("sim_rd_bank", m2.rd_bank, 1);
        check("sim_wr_bank", m2.wr_bank, 0);
        check("sim_rd_ready", m2.rd_ready, 1);
        check("empty_rd_len", m2.rd_len, 0);
        check("sim_err", m2.err, 0);

        // Sparse fill, then read-side protocol errors
        m2.wr_en = 1; m2.wr_addr = 7'd5; m2.wr_din = 8'hC3;
        tick();
        m2.wr_en = 0; m2.wr_finish = 1;
        tick();
        m2.wr_finish = 0;
        check("full2_used", m2.used, 2);
        check("full2_wr_ready", m2.wr_ready, 0);
        check("full2_wr_bank", m2.wr_bank, 1);
        m2.rd_finish = 1;
        tick();
        m2.rd_finish = 0;
        check("sparse_rd_bank", m2.rd_bank, 0);
        check("sparse_rd_len", m2.rd_len, 6);
        check("sparse_used", m2.used, 1);
        check("sparse_wr_ready", m2.wr_ready, 1);
        m2.rd_en = 1; m2.rd_addr = 7'd5;
        tick();
        m2.rd_en = 0;
        check("sparse_dout", m2.rd_dout, 8'hC3);
        m2.rd_finish = 1;
        tick();
        m2.rd_finish = 0;
        check("drain_used", m2.used, 0);
        check("drain_rd_ready", m2.rd_ready, 0);
        check("drain_rd_len", m2.rd_len, 0);
        check("drain_err", m2.err, 0);
        m2.rd_finish = 1;
        tick();
        m2.rd_finish = 0;
        check("badfin_err", m2.err, 1);
        check("badfin_used", m2.used, 0);
        m2.rd_en = 1;
        tick();
        m2.rd_en = 0;
        check("badrd_valid", m2.rd_valid, 0);

        // Four banks, tagged data, odd banks written top-down
        for (int b = 0; b < 4; b++) begin
            lens[b] = b * 20 + 5;
            for (int k = 0; k < lens[b]; k++) begin
                int a;
                a = (b % 2 == 1) ? (lens[b] - 1 - k) : k;
                m4.wr_en = 1; m4.wr_addr = 7'(a); m4.wr_din = tag4(b, a);
                tick();
            end
            m4.wr_en = 0; m4.wr_finish = 1;
            tick();
            m4.wr_finish = 0;
            check("fill4_used", m4.used, b + 1);
            check("fill4_wr_bank", m4.wr_bank, (b + 1) % 4);
        end
        check("full4_wr_ready", m4.wr_ready, 0);
        check("full4_rd_ready", m4.rd_ready, 1);
        m4.wr_en = 1; m4.wr_addr = 7'd0; m4.wr_din = 8'hFF;
        tick();
        m4.wr_en = 0;
        check("full4_err", m4.err, 1);
        check("full4_used", m4.used, 4);
        for (int b = 0; b < 4; b++) begin
            check("drain4_rd_bank", m4.rd_bank, b);
            check("drain4_rd_len", m4.rd_len, lens[b]);
            m4.rd_en = 1; m4.rd_addr = 7'd0;
            tick();
            check("drain4_first", m4.rd_dout, tag4(b, 0));
            m4.rd_addr = 7'(lens[b] - 1);
            tick();
            m4.rd_en = 0;
            check("drain4_last", m4.rd_dout, tag4(b, lens[b] - 1));
            m4.rd_finish = 1;
            m4.wr_finish = (b == 0);
            tick();
            m4.rd_finish = 0; m4.wr_finish = 0;
            if (b == 0) begin
                check("fullfin_used", m4.used, 3);
                check("fullfin_wr_bank", m4.wr_bank, 0);
                check("fullfin_wr_ready", m4.wr_ready, 1);
            end
        end
        check("drain4_used", m4.used, 0);
        check("drain4_rd_ready", m4.rd_ready, 0);

        // Reset with two filled banks and a read in flight
        m2.wr_en = 1; m2.wr_addr = 7'd0; m2.wr_din = 8'h11; m2.wr_finish = 1;
        tick();
        m2.wr_din = 8'h22;
        tick();
        m2.wr_en = 0; m2.wr_finish = 0;
        check("pre_rst_used", m2.used, 2);
        m2.rd_en = 1; m2.rd_addr = 7'd0; rstn = 1'b0;
        tick();
        rstn = 1'b1; m2.rd_en = 0;
        check("mid_rst_used", m2.used, 0);
        check("mid_rst_rd_ready", m2.rd_ready, 0);
        check("mid_rst_rd_valid", m2.rd_valid, 0);
        check("mid_rst_err", m2.err, 0);
        check("mid_rst_wr_ready", m2.wr_ready, 1);
        check("mid_rst_rd_dout", m2.rd_dout, 0);
        check("mid_rst_wr_bank", m2.wr_bank, 0);
        check("mid_rst_rd_len", m2.rd_len, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
